// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: intersection phase controller driving an external
// countdown timer. Each phase loads its duration on its first cycle and ends
// when the timer has run down to zero.
// Optional pedestrian walk phase: define TRAFFIC_PED_WALK_EN to enable it.
// Without it ped_req is ignored, walk is tied low and WALK is unreachable.
module traffic_phase_sequencer #(
  parameter int unsigned COUNT_SIZE  = 7,
  parameter int unsigned GREEN_TIME  = 10,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned ALLRED_TIME = 2,
  parameter int unsigned WALK_TIME   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ew_car,
  input  logic                  ped_req,
  input  logic [COUNT_SIZE-1:0] tmr_count,
  output logic                  tmr_load,
  output logic [COUNT_SIZE-1:0] tmr_load_val,
  output logic                  tmr_down,
  output logic [1:0]            ns_light,
  output logic [1:0]            ew_light,
  output logic                  walk
);

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    ALL_RED_1,
    EW_GREEN,
    EW_YELLOW,
    ALL_RED_2,
    WALK
  } state_t;

  localparam logic [1:0] LAMP_RED = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_GRN = 2'b10;

  localparam logic [COUNT_SIZE-1:0] DUR_GREEN  = COUNT_SIZE'(GREEN_TIME);
  localparam logic [COUNT_SIZE-1:0] DUR_YELLOW = COUNT_SIZE'(YELLOW_TIME);
  localparam logic [COUNT_SIZE-1:0] DUR_ALLRED = COUNT_SIZE'(ALLRED_TIME);
  localparam logic [COUNT_SIZE-1:0] DUR_WALK   = COUNT_SIZE'(WALK_TIME);

  state_t                  r_state;
  logic                    r_load;
  logic [COUNT_SIZE-1:0]   r_load_val;
  logic [1:0]              r_ns;
  logic [1:0]              r_ew;

  state_t                  w_next;
  logic                    w_enter;
  logic                    w_expired;
  logic                    w_ped_eff;

  function automatic logic [COUNT_SIZE-1:0] dur_of(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   dur_of = DUR_GREEN;
      NS_YELLOW, EW_YELLOW: dur_of = DUR_YELLOW;
      WALK:                 dur_of = DUR_WALK;
      default:              dur_of = DUR_ALLRED;
    endcase
  endfunction

  function automatic logic [1:0] ns_lamp(input state_t s);
    case (s)
      NS_GREEN:  ns_lamp = LAMP_GRN;
      NS_YELLOW: ns_lamp = LAMP_YEL;
      default:   ns_lamp = LAMP_RED;
    endcase
  endfunction

  function automatic logic [1:0] ew_lamp(input state_t s);
    case (s)
      EW_GREEN:  ew_lamp = LAMP_GRN;
      EW_YELLOW: ew_lamp = LAMP_YEL;
      default:   ew_lamp = LAMP_RED;
    endcase
  endfunction

`ifdef TRAFFIC_PED_WALK_EN
  typedef enum logic {DIR_NS, DIR_EW} dir_t;

  logic r_ped_pending;
  dir_t r_next_dir;
  logic r_walk;

  // A request arriving in the same cycle as an all-red expiry is honoured
  // immediately rather than waiting for the pending flag to register.
  assign w_ped_eff = r_ped_pending | (ped_req & (r_state != WALK));
`else
  logic w_unused_ped_req;

  assign w_unused_ped_req = ped_req;
  assign w_ped_eff        = 1'b0;
`endif

  // Phase expiry and next-phase selection.
  always_comb begin
    w_expired = ~r_load & (tmr_count == '0);
    w_next    = r_state;
    w_enter   = 1'b0;
    if (w_expired) begin
      w_enter = 1'b1;
      case (r_state)
        NS_GREEN: begin
          // Hold green (no reload, timer parked at zero) until there is demand.
          if (ew_car | w_ped_eff) w_next = NS_YELLOW;
          else                    w_enter = 1'b0;
        end
        NS_YELLOW: w_next = ALL_RED_1;
        ALL_RED_1: w_next = w_ped_eff ? WALK : EW_GREEN;
        EW_GREEN:  w_next = EW_YELLOW;
        EW_YELLOW: w_next = ALL_RED_2;
        ALL_RED_2: w_next = w_ped_eff ? WALK : NS_GREEN;
`ifdef TRAFFIC_PED_WALK_EN
        WALK:      w_next = (r_next_dir == DIR_EW) ? EW_GREEN : NS_GREEN;
`endif
        default:   w_next = ALL_RED_2;
      endcase
    end
  end

  // Phase register with registered lamp and timer-load outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ALL_RED_2;
      r_load     <= 1'b1;
      r_load_val <= DUR_ALLRED;
      r_ns       <= LAMP_RED;
      r_ew       <= LAMP_RED;
    end else begin
      r_load <= w_enter;
      if (w_enter) begin
        r_state    <= w_next;
        r_load_val <= dur_of(w_next);
        r_ns       <= ns_lamp(w_next);
        r_ew       <= ew_lamp(w_next);
      end
    end
  end

`ifdef TRAFFIC_PED_WALK_EN
  // Pedestrian request latch, return direction and walk lamp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ped_pending <= 1'b0;
      r_next_dir    <= DIR_NS;
      r_walk        <= 1'b0;
    end else begin
      if (w_enter) r_walk <= (w_next == WALK);
      if (w_enter && (w_next == WALK)) begin
        r_ped_pending <= 1'b0;
        r_next_dir    <= (r_state == ALL_RED_1) ? DIR_EW : DIR_NS;
      end else if (ped_req && (r_state != WALK)) begin
        r_ped_pending <= 1'b1;
      end
    end
  end

  assign walk = r_walk;
`else
  assign walk = 1'b0;
`endif

  assign tmr_load     = r_load;
  assign tmr_load_val = r_load_val;
  assign tmr_down     = ~r_load;
  assign ns_light     = r_ns;
  assign ew_light     = r_ew;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Testbench for traffic_phase_sequencer: phase tables, directed corner
// sequences and a randomized run against a phase/age reference model.
module tb_traffic_phase_sequencer;

  localparam int CS = 7;
  localparam int GT = 10;
  localparam int YT = 3;
  localparam int AT = 2;
  localparam int WT = 5;

`ifdef TRAFFIC_PED_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ew_car = 1'b0;
  logic          ped_req = 1'b0;
  logic [CS-1:0] tmr_count = '0;
  logic          tmr_load;
  logic [CS-1:0] tmr_load_val;
  logic          tmr_down;
  logic [1:0]    ns_light;
  logic [1:0]    ew_light;
  logic          walk;

  int checks = 0;
  int failures = 0;

  traffic_phase_sequencer #(
    .COUNT_SIZE (CS),
    .GREEN_TIME (GT),
    .YELLOW_TIME(YT),
    .ALLRED_TIME(AT),
    .WALK_TIME  (WT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ew_car      (ew_car),
    .ped_req     (ped_req),
    .tmr_count   (tmr_count),
    .tmr_load    (tmr_load),
    .tmr_load_val(tmr_load_val),
    .tmr_down    (tmr_down),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .walk        (walk)
  );

  always #5 clk = ~clk;

  // External countdown timer: load, else decrement, saturating at zero.
  always @(posedge clk) begin
    if (tmr_load) tmr_count <= tmr_load_val;
    else if (tmr_down && tmr_count != '0) tmr_count <= tmr_count - 1'b1;
  end

  // ---------------- reference model: phase index + cycles spent in it
  localparam int P_NSG = 0, P_NSY = 1, P_AR1 = 2, P_EWG = 3, P_EWY = 4, P_AR2 = 5, P_WALK = 6;
  int dur_tab [7] = '{GT, YT, AT, GT, YT, AT, WT};
  int ring_tab[7] = '{P_NSY, P_AR1, P_EWG, P_EWY, P_AR2, P_NSG, P_NSG};
  int ns_tab  [7] = '{2, 1, 0, 0, 0, 0, 0};
  int ew_tab  [7] = '{0, 0, 0, 2, 1, 0, 0};

  int m_ph, m_age, m_dir;
  bit m_pend;

  task automatic model_reset();
    m_ph = P_AR2; m_age = 0; m_pend = 1'b0; m_dir = P_NSG;
  endtask

  task automatic model_step(input bit ew, input bit ped);
    bit pe, go;
    int nx;
    pe = PED && (m_pend || (ped && m_ph != P_WALK));
    go = 1'b0;
    nx = m_ph;
    if (m_age >= dur_tab[m_ph] + 1) begin
      go = 1'b1;
      if (m_ph == P_NSG) begin
        if (ew || pe) nx = P_NSY; else go = 1'b0;
      end else if ((m_ph == P_AR1 || m_ph == P_AR2) && pe) begin
        nx = P_WALK;
        m_dir = (m_ph == P_AR1) ? P_EWG : P_NSG;
      end else if (m_ph == P_WALK) begin
        nx = m_dir;
      end else begin
        nx = ring_tab[m_ph];
      end
    end
    if (PED) begin
      if (go && nx == P_WALK) m_pend = 1'b0;
      else if (ped && m_ph != P_WALK) m_pend = 1'b1;
    end
    if (go) begin m_ph = nx; m_age = 0; end
    else m_age++;
  endtask

  function automatic logic [31:0] mk(input bit ld, input int val, input int ns, input int ew, input bit wk);
    mk = {18'b0, ld, 7'(val), ~ld, 2'(ns), 2'(ew), wk};
  endfunction

  function automatic logic [31:0] model_exp();
    model_exp = mk(m_age == 0, dur_tab[m_ph], ns_tab[m_ph], ew_tab[m_ph], m_ph == P_WALK);
  endfunction

  function automatic logic [31:0] actual();
    actual = {18'b0, tmr_load, tmr_load_val, tmr_down, ns_light, ew_light, walk};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance one clock: model follows the inputs seen at the edge; resume after the falling edge.
  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step(ew_car, ped_req);
    @(negedge clk);
    #1;
  endtask

  localparam logic [31:0] RESET_VALS = {18'b0, 1'b1, 7'(AT), 1'b0, 2'b00, 2'b00, 1'b0};

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    chk("reset_vals", actual(), RESET_VALS);
    step();
    step();
    chk("reset_held", actual(), RESET_VALS);
    rst = 1'b1;
  endtask

  // ---------------- phase tables
  typedef struct {
    bit ew;
    int ped;   // 0 none, 1 pulse on first cycle, 2 held, 3 every 4th cycle
    int len;
    int ns;
    int ewl;
    bit wk;
    int val;
    bit cont;  // continuation of a held phase: no load on its first cycle
  } row_t;

  row_t rows[$];

  function automatic row_t R(input bit ew, input int ped, input int len, input int ns,
                             input int ewl, input bit wk, input int val, input bit cont);
    R.ew = ew; R.ped = ped; R.len = len; R.ns = ns; R.ewl = ewl;
    R.wk = wk; R.val = val; R.cont = cont;
  endfunction

  task automatic run_rows(input string tag);
    for (int r = 0; r < rows.size(); r++) begin
      for (int c = 0; c < rows[r].len; c++) begin
        ew_car  = rows[r].ew;
        ped_req = (rows[r].ped == 2) || (rows[r].ped == 1 && c == 0) ||
                  (rows[r].ped == 3 && (c % 4) == 0);
        chk($sformatf("%s_r%0d_c%0d", tag, r, c), actual(),
            mk(c == 0 && !rows[r].cont, rows[r].val, rows[r].ns, rows[r].ewl, rows[r].wk));
        step();
      end
    end
  endtask

  task automatic push_cycle_ew();
    rows.push_back(R(1, 0, AT + 2, 0, 0, 0, AT, 0));  // ALL_RED_2
    rows.push_back(R(1, 0, GT + 2, 2, 0, 0, GT, 0));  // NS_GREEN
    rows.push_back(R(1, 0, YT + 2, 1, 0, 0, YT, 0));  // NS_YELLOW
    rows.push_back(R(1, 0, AT + 2, 0, 0, 0, AT, 0));  // ALL_RED_1
    rows.push_back(R(1, 0, GT + 2, 0, 2, 0, GT, 0));  // EW_GREEN
    rows.push_back(R(1, 0, YT + 2, 0, 1, 0, YT, 0));  // EW_YELLOW
  endtask

  initial begin
    @(negedge clk);
    #1;

    // Full cycle with ew_car held, then NS_GREEN held with no demand.
    do_reset();
    rows.delete();
    push_cycle_ew();
    rows.push_back(R(1, 0, AT + 2, 0, 0, 0, AT, 0));
    rows.push_back(R(0, 0, GT + 2, 2, 0, 0, GT, 0));
    rows.push_back(R(0, 0, 40 - (GT + 2), 2, 0, 0, GT, 1));
    rows.push_back(R(1, 0, 1, 2, 0, 0, GT, 1));        // ew_car rises at cycle 40
    rows.push_back(R(1, 0, YT + 2, 1, 0, 0, YT, 0));
    rows.push_back(R(1, 0, AT + 2, 0, 0, 0, AT, 0));
    rows.push_back(R(1, 0, 3, 0, 2, 0, GT, 0));        // partway into EW_GREEN
    run_rows("seq");

    // Asynchronous reset mid EW_GREEN, visible before the next rising edge.
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset", actual(), RESET_VALS);
    step();
    rst = 1'b1;
    model_reset();
    rows.delete();
    push_cycle_ew();
    run_rows("after_rst");

`ifdef TRAFFIC_PED_WALK_EN
    // Single pedestrian pulse during EW_GREEN, served after ALL_RED_2.
    do_reset();
    rows.delete();
    rows.push_back(R(1, 0, AT + 2, 0, 0, 0, AT, 0));
    rows.push_back(R(1, 0, GT + 2, 2, 0, 0, GT, 0));
    rows.push_back(R(1, 0, YT + 2, 1, 0, 0, YT, 0));
    rows.push_back(R(1, 0, AT + 2, 0, 0, 0, AT, 0));
    rows.push_back(R(1, 1, GT + 2, 0, 2, 0, GT, 0));
    rows.push_back(R(1, 0, YT + 2, 0, 1, 0, YT, 0));
    rows.push_back(R(1, 0, AT + 2, 0, 0, 0, AT, 0));
    rows.push_back(R(1, 0, WT + 2, 0, 0, 1, WT, 0));
    rows.push_back(R(1, 0, GT + 2, 2, 0, 0, GT, 0));
    rows.push_back(R(1, 0, YT + 2, 1, 0, 0, YT, 0));
    rows.push_back(R(1, 0, AT + 2, 0, 0, 0, AT, 0));
    rows.push_back(R(1, 0, GT + 2, 0, 2, 0, GT, 0));
    run_rows("ped_pulse");

    // Request held through WALK gives one walk; a later pulse is served after ALL_RED_1.
    do_reset();
    rows.delete();
    rows.push_back(R(1, 0, AT + 2, 0, 0, 0, AT, 0));
    rows.push_back(R(1, 0, GT + 2, 2, 0, 0, GT, 0));
    rows.push_back(R(1, 0, YT + 2, 1, 0, 0, YT, 0));
    rows.push_back(R(1, 2, AT + 2, 0, 0, 0, AT, 0));
    rows.push_back(R(1, 2, WT + 2, 0, 0, 1, WT, 0));
    rows.push_back(R(1, 0, GT + 2, 0, 2, 0, GT, 0));
    rows.push_back(R(1, 0, YT + 2, 0, 1, 0, YT, 0));
    rows.push_back(R(1, 0, AT + 2, 0, 0, 0, AT, 0));
    rows.push_back(R(1, 1, GT + 2, 2, 0, 0, GT, 0));
    rows.push_back(R(1, 0, YT + 2, 1, 0, 0, YT, 0));
    rows.push_back(R(1, 0, AT + 2, 0, 0, 0, AT, 0));
    rows.push_back(R(1, 0, WT + 2, 0, 0, 1, WT, 0));
    rows.push_back(R(1, 0, GT + 2, 0, 2, 0, GT, 0));
    run_rows("ped_hold");
`else
    // Pedestrian requests are ignored: no walk, NS_GREEN stays held.
    do_reset();
    rows.delete();
    rows.push_back(R(0, 3, AT + 2, 0, 0, 0, AT, 0));
    rows.push_back(R(0, 3, GT + 2, 2, 0, 0, GT, 0));
    rows.push_back(R(0, 3, 60, 2, 0, 0, GT, 1));
    run_rows("no_ped");
`endif

    // Randomized run against the reference model, with occasional async resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      chk($sformatf("rand_%0d", i), actual(), model_exp());
      chk($sformatf("safety_%0d", i),
          {29'b0, (ns_light != 2'b00) && (ew_light != 2'b00), ns_light == 2'b11, ew_light == 2'b11},
          32'd0);
      if ($urandom_range(0, 9) < 2) ew_car = ~ew_car;
      ped_req = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
